// File: rtl/vga_sync_monitor.sv
// VGA receive-side monitor: recovers x/y from hsync/vsync, checks line/frame timing,
// declares lock and signs every locked frame. Define VGA_MON_CRC_EN for a CRC-16-CCITT signature.
module vga_sync_monitor #(
    parameter int CD          = 12,
    parameter int HD          = 640,
    parameter int HF          = 16,
    parameter int HB          = 48,
    parameter int HR          = 96,
    parameter int VD          = 480,
    parameter int VF          = 10,
    parameter int VB          = 33,
    parameter int VR          = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_tick,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [CD-1:0] rgb_in,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          video_on,
    output logic          locked,
    output logic [10:0]   h_total,
    output logic [10:0]   v_total,
    output logic [15:0]   frame_sum,
    output logic          frame_done,
    output logic          sync_err
);
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam logic [10:0] HT_L    = 11'(HT);
    localparam logic [10:0] VT_L    = 11'(VT);
    localparam logic [10:0] WD_L    = 11'(2 * HT);
    localparam logic [10:0] HD_L    = 11'(HD);
    localparam logic [10:0] VD_L    = 11'(VD);
    localparam logic [11:0] XOFF    = 12'(HD + HF);
    localparam logic [11:0] YOFF    = 12'(VD + VF);
    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [7:0]  LOCK_L  = 8'(LOCK_FRAMES);
`ifdef VGA_MON_CRC_EN
    localparam logic [15:0] SIG_INIT = 16'hFFFF;
`else
    localparam logic [15:0] SIG_INIT = 16'h0000;
`endif

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 11'd1;
    endfunction

    // Counters are zeroed at the sync edge, so shift by display+front porch and fold once.
    function automatic logic [10:0] wrap_coord(input logic [10:0] cnt, input logic [11:0] off,
                                               input int total);
        logic [11:0] sum;
        sum = {1'b0, cnt} + off;
        if (sum >= 12'(total)) sum = sum - 12'(total);
        return sum[10:0];
    endfunction

    function automatic logic [15:0] sig_step(input logic [15:0] acc, input logic [CD-1:0] pix);
`ifdef VGA_MON_CRC_EN
        logic [15:0] c;
        c = acc;
        for (int i = CD - 1; i >= 0; i--) begin
            if (c[15] ^ pix[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                c = {c[14:0], 1'b0};
        end
        return c;
`else
        return acc + 16'(pix);
`endif
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [10:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        h_bad_q, h_bad_d;
    logic        locked_q, locked_d, video_on_q, video_on_d;
    logic        frame_done_q, frame_done_d, sync_err_q, sync_err_d;
    logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;

    logic        h_fall, v_fall, h_len_ok, v_len_ok, frame_ok, wd_trip, lock_fail;
    logic [10:0] hcnt_inc, vcnt_inc, v_len;

    always_comb begin
        h_fall    = pix_tick && hs_q && !hsync_in;
        v_fall    = pix_tick && vs_q && !vsync_in;
        hcnt_inc  = sat_inc(hcnt_q);
        vcnt_inc  = sat_inc(vcnt_q);
        // A line edge coinciding with the frame edge still belongs to the closing frame.
        v_len     = h_fall ? vcnt_inc : vcnt_q;
        h_len_ok  = (hcnt_inc == HT_L);
        v_len_ok  = (v_len == VT_L);
        frame_ok  = v_len_ok && !h_bad_q && !(h_fall && !h_len_ok);
        wd_trip   = pix_tick && !h_fall && (hcnt_inc == WD_L);
        lock_fail = (state_q == LOCKED) && ((h_fall && !h_len_ok) || (v_fall && !v_len_ok));
    end

    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        h_bad_d   = h_bad_q;
        x_d       = x_q;
        y_d       = y_q;
        if (pix_tick) begin
            hs_d = hsync_in;
            vs_d = vsync_in;
            if (h_fall) begin
                h_total_d = hcnt_inc;
                hcnt_d    = '0;
                vcnt_d    = vcnt_inc;
                if (!h_len_ok) h_bad_d = 1'b1;
            end else begin
                hcnt_d = hcnt_inc;
            end
            if (v_fall) begin
                v_total_d = v_len;
                vcnt_d    = '0;
            end
            // Errors already reported do not count against the next frame's measurement.
            if (v_fall || lock_fail || wd_trip) h_bad_d = 1'b0;
            x_d = wrap_coord(hcnt_d, XOFF, HT);
            y_d = wrap_coord(vcnt_d, YOFF, VT);
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (wd_trip) begin
            state_d = SEARCH;
            good_d  = '0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (v_fall) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE: begin
                    if (v_fall) begin
                        if (!frame_ok) begin
                            good_d = '0;
                        end else if (good_q + 8'd1 >= LOCK_L) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_fail) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_d     = (state_d == LOCKED);
        sync_err_d   = wd_trip || lock_fail || ((state_q == MEASURE) && v_fall && !frame_ok);
        frame_done_d = (state_q == LOCKED) && v_fall && !lock_fail && !wd_trip;
        video_on_d   = locked_d && (x_d < HD_L) && (y_d < VD_L);
    end

    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (pix_tick && video_on_d) acc_d = sig_step(acc_q, rgb_in);
        if (frame_done_d) begin
            frame_sum_d = acc_d;
            acc_d       = SIG_INIT;
        end
        if ((state_q == LOCKED) && (state_d != LOCKED)) acc_d = SIG_INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            h_bad_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            locked_q     <= 1'b0;
            video_on_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            acc_q        <= SIG_INIT;
            frame_sum_q  <= '0;
        end else begin
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            h_bad_q      <= h_bad_d;
            x_q          <= x_d;
            y_q          <= y_d;
            locked_q     <= locked_d;
            video_on_q   <= video_on_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            acc_q        <= acc_d;
            frame_sum_q  <= frame_sum_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign video_on   = video_on_q;
    assign locked     = locked_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign frame_sum  = frame_sum_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced 25x12 video mode; the stimulus model
// is an ideal sync generator whose hc/vc the recovered coordinates are compared against.
module tb_vga_sync_monitor;
    localparam int HD = 16, HF = 2, HB = 3, HR = 4;
    localparam int VD = 8,  VF = 1, VB = 2, VR = 1;
    localparam int HT = HD + HF + HB + HR;   // 25
    localparam int VT = VD + VF + VB + VR;   // 12

    logic        clk = 1'b0;
    logic        reset, pix_tick, hsync_in, vsync_in;
    logic [11:0] rgb_in;
    logic [10:0] x, y, h_total, v_total;
    logic        video_on, locked, frame_done, sync_err;
    logic [15:0] frame_sum;

    vga_sync_monitor #(
        .CD(12), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .rgb_in(rgb_in), .x(x), .y(y), .video_on(video_on),
        .locked(locked), .h_total(h_total), .v_total(v_total), .frame_sum(frame_sum),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    int          hc = 0, vc = 0, line_len = HT, gap = 4;
    int          n_err = 0, n_done = 0, stray = 0, xy_bad = 0;
    logic        hs_force = 1'b0, chk_xy = 1'b0, jitter = 1'b0, vf_seen = 1'b0;
    logic [11:0] rgb_val = 12'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] exp_sig(input logic [11:0] v);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int p = 0; p < HD * VD; p++)
            for (int b = 11; b >= 0; b--)
                c = (c[15] ^ v[b]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction
`else
    // 128 active pixels per frame: 128*1 = 0x0080, 128*3 = 0x0180, 128*4095 mod 2^16 = 0xFF80.
    function automatic logic [15:0] exp_sig(input logic [11:0] v);
        case (v)
            12'h001: return 16'h0080;
            12'h003: return 16'h0180;
            12'hFFF: return 16'hFF80;
            default: return 16'h0000;
        endcase
    endfunction
`endif

    // One generator pixel: drive, tick, observe, idle gap, advance.
    task automatic step();
        hsync_in = hs_force | !(hc >= HD + HF && hc < HD + HF + HR);
        vsync_in = !(vc >= VD + VF && vc < VD + VF + VR);
        rgb_in   = rgb_val;
        if (hc == 0 && vc == VD + VF) vf_seen = 1'b1;
        if (jitter) gap = $urandom_range(5, 1);
        pix_tick = 1'b1;
        @(posedge clk); #1;
        pix_tick = 1'b0;
        if (sync_err)   n_err++;
        if (frame_done) n_done++;
        if (chk_xy) begin
            if (x !== 11'(hc)) xy_bad++;
            // Row advances at the hsync edge, so y is compared up to the end of the front porch.
            if (hc < HD + HF && y !== 11'(vc)) xy_bad++;
            if (video_on !== (hc < HD && vc < VD)) xy_bad++;
        end
        for (int g = 1; g < gap; g++) begin
            @(posedge clk); #1;
            if (sync_err || frame_done) stray++;
        end
        hc++;
        if (hc >= line_len) begin
            hc       = 0;
            line_len = HT;
            vc       = (vc + 1) % VT;
        end
    endtask

    task automatic run_to_vfall();
        int guard;
        guard   = 0;
        vf_seen = 1'b0;
        while (!vf_seen && guard < 2 * HT * VT) begin
            step();
            guard++;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int guard;
        guard = 0;
        while (!(hc == h && vc == v) && guard < 2 * HT * VT) begin
            step();
            guard++;
        end
    endtask

    task automatic check_zero(input string p);
        chk({p, "_x"}, 32'(x), 0);
        chk({p, "_y"}, 32'(y), 0);
        chk({p, "_video_on"}, 32'(video_on), 0);
        chk({p, "_locked"}, 32'(locked), 0);
        chk({p, "_h_total"}, 32'(h_total), 0);
        chk({p, "_v_total"}, 32'(v_total), 0);
        chk({p, "_frame_sum"}, 32'(frame_sum), 0);
        chk({p, "_frame_done"}, 32'(frame_done), 0);
        chk({p, "_sync_err"}, 32'(sync_err), 0);
    endtask

    task automatic relock(input string p);
        run_to_vfall();
        chk({p, "_lock_f1"}, 32'(locked), 0);
        run_to_vfall();
        chk({p, "_lock_f2"}, 32'(locked), 0);
        run_to_vfall();
        chk({p, "_lock_f3"}, 32'(locked), 1);
    endtask

    initial begin
        reset    = 1'b1;
        pix_tick = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in   = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // Lock from reset on the third vsync fall, then track a whole frame.
        relock("t1");
        chk("t1_no_err", 32'(n_err), 0);
        chk("t1_h_total", 32'(h_total), HT);
        chk("t1_v_total", 32'(v_total), VT);
        chk_xy = 1'b1;
        run_to_vfall();
        chk_xy = 1'b0;
        chk("t1_xy_track", 32'(xy_bad), 0);

        // Signatures of constant frames.
        rgb_val = 12'h001;
        n_done  = 0;
        run_to_vfall();
        chk("t2_sum_ones", 32'(frame_sum), 32'(exp_sig(12'h001)));
        chk("t2_done_cnt", 32'(n_done), 1);
        rgb_val = 12'hFFF;
        n_done  = 0;
        run_to_vfall();
        chk("t2_sum_fff", 32'(frame_sum), 32'(exp_sig(12'hFFF)));
        chk("t2_done_cnt2", 32'(n_done), 1);
        chk("t2_locked", 32'(locked), 1);
        rgb_val = 12'h000;

        // One 26-pixel line while locked.
        run_to(0, 3);
        line_len = HT + 1;
        n_err    = 0;
        run_to(HD + HF, 4);
        step();
        chk("t3_err_pulse", 32'(n_err), 1);
        chk("t3_unlocked", 32'(locked), 0);
        chk("t3_h_total", 32'(h_total), HT + 1);
        run_to_vfall();
        chk("t3_lock_f1", 32'(locked), 0);
        run_to_vfall();
        chk("t3_relock", 32'(locked), 1);
        chk("t3_err_once", 32'(n_err), 1);

        // Missing hsync for 2*HT ticks: watchdog back to SEARCH.
        run_to(0, 2);
        n_err    = 0;
        hs_force = 1'b1;
        repeat (2 * HT) step();
        hs_force = 1'b0;
        chk("t4_wd_err", 32'(n_err), 1);
        chk("t4_unlocked", 32'(locked), 0);
        relock("t4");
        chk("t4_err_once", 32'(n_err), 1);

        // One-clock reset mid-frame.
        run_to(0, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("t5");
        n_err = 0;
        relock("t5");
        chk("t5_no_err", 32'(n_err), 0);

        // Irregular pix_tick spacing must not change the signature.
        jitter = 1'b1;
`ifdef VGA_MON_CRC_EN
        rgb_val = 12'h000;
`else
        rgb_val = 12'h003;
`endif
        n_done = 0;
        run_to_vfall();
        chk("t6_jitter_sum", 32'(frame_sum), 32'(exp_sig(rgb_val)));
        chk("t6_done_cnt", 32'(n_done), 1);
        chk("t6_locked", 32'(locked), 1);
        jitter = 1'b0;
        gap    = 4;

        chk("stray_pulse", 32'(stray), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
